mem_initiator: RTL and testbench

//   Bus master for the strobe/rdy word-memory protocol. Turns a single-beat host

---
 rtl/mem_initiator.sv | 104 ++++++++++
 tb/tb_mem_initiator.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_initiator.sv
// Strobe/rdy word-memory bus master: one host request becomes one bus transaction.
// Optional WAIT-state timeout abort is enabled by defining MEM_INIT_TIMEOUT_EN.
module mem_initiator #(
    parameter int ADDR_W         = 8,
    parameter int DATA_W         = 16,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              req_ready,
    output logic              rsp_valid,
    output logic              rsp_err,
    output logic [DATA_W-1:0] rd_data,
    output logic [ADDR_W-1:0] addr,
    output logic              rw,
    output logic              strb,
    inout  wire  [DATA_W-1:0] data,
    input  logic              rdy
);

    typedef enum logic [1:0] {IDLE, STROBE, WAIT, DONE} state_t;

    state_t            state;
    logic              drive;
    logic [DATA_W-1:0] wdata;

    assign data      = drive ? wdata : {DATA_W{1'bz}};
    assign req_ready = (state == IDLE);

`ifdef MEM_INIT_TIMEOUT_EN
    localparam int CW = ($clog2(TIMEOUT_CYCLES + 1) > 5) ? $clog2(TIMEOUT_CYCLES + 1) : 5;
    logic [CW-1:0] tmo_cnt;
`else
    assign rsp_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            strb      <= 1'b1;
            rw        <= 1'b1;
            addr      <= '0;
            wdata     <= '0;
            drive     <= 1'b0;
            rsp_valid <= 1'b0;
            rd_data   <= '0;
`ifdef MEM_INIT_TIMEOUT_EN
            rsp_err   <= 1'b0;
            tmo_cnt   <= '0;
`endif
        end else begin
            rsp_valid <= 1'b0;
`ifdef MEM_INIT_TIMEOUT_EN
            rsp_err   <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (req) begin
                        addr  <= req_addr;
                        rw    <= ~req_we;
                        wdata <= req_wdata;
                        drive <= req_we;
                        strb  <= 1'b0;
                        state <= STROBE;
                    end
                end
                STROBE: begin
                    strb  <= 1'b1;
                    state <= WAIT;
`ifdef MEM_INIT_TIMEOUT_EN
                    tmo_cnt <= '0;
`endif
                end
                WAIT: begin
                    // rdy takes priority over a timeout landing on the same edge
                    if (!rdy) begin
                        if (rw) rd_data <= data;
                        drive     <= 1'b0;
                        rsp_valid <= 1'b1;
                        state     <= DONE;
                    end
`ifdef MEM_INIT_TIMEOUT_EN
                    else if (tmo_cnt == CW'(TIMEOUT_CYCLES - 1)) begin
                        drive     <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b1;
                        state     <= DONE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
`endif
                end
                // One idle cycle lets the responder's rdy return high before the next strobe
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_initiator.sv
// Scoreboard bench for mem_initiator with a behavioural 2-cycle-delay responder
// and a pulled-up data bus so a released bus reads as all ones.
module tb_mem_initiator;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req = 1'b0;
    logic        req_we = 1'b0;
    logic [7:0]  req_addr = '0;
    logic [15:0] req_wdata = '0;
    logic        req_ready, rsp_valid, rsp_err, rw, strb, rdy;
    logic [15:0] rd_data;
    logic [7:0]  addr;
    wire  [15:0] data;

    mem_initiator dut (
        .clk(clk), .rst_n(rst_n), .req(req), .req_we(req_we), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_ready(req_ready), .rsp_valid(rsp_valid),
        .rsp_err(rsp_err), .rd_data(rd_data), .addr(addr), .rw(rw), .strb(strb),
        .data(data), .rdy(rdy)
    );

    always #5 clk = ~clk;

    for (genvar i = 0; i < 16; i++) begin : g_pu
        pullup pu (data[i]);
    end

    // Responder: sees strobe at T1, drives rdy low T3-T4, writes memory at T4
    logic [15:0] mem [256];
    logic        rdy_r = 1'b1, spur = 1'b0, resp_en = 1'b1, rdrv = 1'b0, rrw = 1'b1;
    logic [15:0] rq = '0;
    logic [7:0]  ra = '0;
    int          rc = 0;

    assign rdy  = rdy_r & ~spur;
    assign data = rdrv ? rq : 16'bz;

    always @(posedge clk) begin
        case (rc)
            0: if (resp_en && !strb) begin rc <= 1; ra <= addr; rrw <= rw; end
            1: rc <= 2;
            2: begin
                rdy_r <= 1'b0;
                if (rrw) begin rdrv <= 1'b1; rq <= mem[ra]; end
                rc <= 3;
            end
            default: begin
                rdy_r <= 1'b1;
                rdrv  <= 1'b0;
                if (!rrw) mem[ra] <= data;
                rc <= 0;
            end
        endcase
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0, errors = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    typedef struct {
        logic        err;
        logic [15:0] rd;
        int          acc;
        int          lat;
    } exp_t;
    exp_t q[$];

    // Response monitor
    always @(negedge clk) begin
        if (rst_n && rsp_valid) begin
            if (q.size() == 0) begin
                check("unexpected_rsp", 1, 0);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("rsp_err", rsp_err, e.err);
                check("rd_data", rd_data, e.rd);
                check("latency", cyc - e.acc, e.lat);
            end
        end
    end

    // Bus monitor: strobe is one cycle wide and never overlaps rdy low
    logic prev_strb = 1'b1;
    always @(negedge clk) begin
        if (rst_n && !strb) begin
            check("strb_width", prev_strb, 1);
            check("strb_rdy_overlap", rdy, 1);
        end
        prev_strb = strb;
    end

    task automatic issue(input logic we, input logic [7:0] a, input logic [15:0] wd,
                         input logic [15:0] exp_rd, input logic exp_err, input int lat,
                         input bit hold, input bit push, output int acc);
        int n = 0;
        req = 1'b1; req_we = we; req_addr = a; req_wdata = wd;
        while (!req_ready && n < 50) begin @(negedge clk); #1; n++; end
        if (n >= 50) begin
            check("accept_timeout", 1, 0);
            req = 1'b0;
            acc = -1;
        end else begin
            acc = cyc + 1;
            if (push) q.push_back('{exp_err, exp_rd, acc, lat});
            @(negedge clk);
            if (!hold) req = 1'b0;
        end
    endtask

    task automatic drain();
        int n = 0;
        while ((q.size() != 0 || !req_ready) && n < 200) begin @(negedge clk); #1; n++; end
        if (n >= 200) check("drain_timeout", 1, 0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int a0, a1, a2, a3;
        logic [15:0] last_rd;
        last_rd = 16'h0;

        // Reset state
        #12;
        check("rst_strb", strb, 1);
        check("rst_rw", rw, 1);
        check("rst_addr", addr, 0);
        check("rst_data", data, 16'hFFFF);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_err", rsp_err, 0);
        check("rst_rd_data", rd_data, 0);
        check("rst_req_ready", req_ready, 1);
        @(negedge clk); rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // 1: write 0x12 <- 0xBEEF
        issue(1, 8'h12, 16'hBEEF, last_rd, 0, 4, 0, 1, a0);
        check("t1_strb_low", strb, 0);
        check("t1_rw", rw, 0);
        check("t1_addr", addr, 8'h12);
        check("t1_data_T0", data, 16'hBEEF);
        repeat (3) begin @(negedge clk); check("t1_data_held", data, 16'hBEEF); end
        @(negedge clk);
        check("t1_rsp_valid", rsp_valid, 1);
        check("t1_data_released", data, 16'hFFFF);
        drain();

        // 2: read 0x12
        last_rd = 16'hBEEF;
        issue(0, 8'h12, 16'h0000, last_rd, 0, 4, 0, 1, a0);
        for (int i = 0; i < 3; i++) begin
            check("t2_data_undriven", data, 16'hFFFF);
            check("t2_rw", rw, 1);
            @(negedge clk);
        end
        drain();
        check("t2_rd_data", rd_data, 16'hBEEF);

        // 3: back-to-back with req held high
        @(negedge clk);
        issue(1, 8'h00, 16'h1234, last_rd, 0, 4, 1, 1, a0);
        issue(1, 8'hFF, 16'h5678, last_rd, 0, 4, 1, 1, a1);
        issue(0, 8'hFF, 16'h0000, 16'h5678, 0, 4, 1, 1, a2);
        issue(0, 8'h00, 16'h0000, 16'h1234, 0, 4, 0, 1, a3);
        check("t3_spacing_0", a1 - a0, 6);
        check("t3_spacing_1", a2 - a1, 6);
        check("t3_spacing_2", a3 - a2, 6);
        drain();
        last_rd = 16'h1234;

        // 4: reset during WAIT of a write
        @(negedge clk);
        issue(1, 8'h40, 16'hAAAA, last_rd, 0, 4, 0, 1, a0);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("t4_strb", strb, 1);
        check("t4_data", data, 16'hFFFF);
        check("t4_rsp_valid", rsp_valid, 0);
        check("t4_req_ready", req_ready, 1);
        check("t4_rd_data", rd_data, 0);
        q.delete();
        last_rd = 16'h0;
        @(negedge clk); rst_n = 1'b1;
        repeat (4) @(negedge clk);
        issue(0, 8'h12, 16'h0000, 16'hBEEF, 0, 4, 0, 1, a0);
        drain();
        last_rd = 16'hBEEF;

        // 6: spurious rdy pulse in IDLE
        @(negedge clk); spur = 1'b1;
        @(negedge clk); spur = 1'b0;
        repeat (2) begin
            @(negedge clk);
            check("t6_req_ready", req_ready, 1);
            check("t6_rsp_valid", rsp_valid, 0);
        end
        issue(0, 8'hFF, 16'h0000, 16'h5678, 0, 4, 0, 1, a0);
        drain();
        last_rd = 16'h5678;

        // 5: rdy stuck high
        resp_en = 1'b0;
        @(negedge clk);
`ifdef MEM_INIT_TIMEOUT_EN
        issue(0, 8'h00, 16'h0000, last_rd, 1, 17, 0, 1, a0);
        drain();
        check("t5_data", data, 16'hFFFF);
        check("t5_rd_data_kept", rd_data, last_rd);
`else
        issue(0, 8'h00, 16'h0000, last_rd, 0, 4, 0, 0, a0);
        repeat (30) @(negedge clk);
        check("t5_stuck_req_ready", req_ready, 0);
        rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        check("t5_recover_ready", req_ready, 1);
`endif
        resp_en = 1'b1;
        repeat (4) @(negedge clk);
        issue(0, 8'h12, 16'h0000, 16'hBEEF, 0, 4, 0, 1, a0);
        drain();

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
